// File: rtl/pe_pkg.sv
// Shared definitions for the spiking convolution row PE: packet type codes,
// controller states and packet header layout helpers.
package pe_pkg;

    localparam int TYPE_W = 3;

    localparam logic [TYPE_W-1:0] PKT_FILTER = 3'b000;
    localparam logic [TYPE_W-1:0] PKT_IFMAP  = 3'b001;
    localparam logic [TYPE_W-1:0] PKT_PSUM   = 3'b010;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_e;

    // Header is {src, dst, type} at the top of the packet; offsets count down from the MSB.
    function automatic int hdr_w(input int addr_w);
        return 2 * addr_w + TYPE_W;
    endfunction

    function automatic int dst_msb_ofs(input int addr_w);
        return addr_w;
    endfunction

    function automatic int type_msb_ofs(input int addr_w);
        return 2 * addr_w;
    endfunction

endpackage

// File: rtl/pe_psum_unit.sv
// K-tap spike-gated adder: one partial sum of the output row, selected by idx.
module pe_psum_unit #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int N_OUT  = 3,
    parameter int IDX_W  = 2,
    parameter int PSUM_W = 10
) (
    input  logic [K*DATA_W-1:0]  w_i,
    input  logic [K+N_OUT-2:0]   m_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic [PSUM_W-1:0]    psum_o
);

    localparam int M_W = K + N_OUT - 1;

    // Tap k pairs weight w[K-1-k] with spike m[K+N_OUT-2-idx-k].
    always_comb begin
        int pos;
        pos    = 0;
        psum_o = '0;
        for (int k = 0; k < K; k++) begin
            pos    = M_W - 1 - int'(idx_i) - k;
            psum_o = psum_o + (((pos >= 0) && (pos < M_W) && m_i[pos])
                               ? PSUM_W'(w_i[(K-1-k)*DATA_W +: DATA_W])
                               : PSUM_W'(0));
        end
    end

endmodule

// File: rtl/pe_conv_row.sv
// Convolution row PE: gathers one filter row and one ifmap row from the NoC,
// then streams the row's partial sums out as individual psum packets.
module pe_conv_row
    import pe_pkg::*;
#(
    parameter int                 WIDTH      = 35,
    parameter int                 ADDR_W     = 4,
    parameter int                 DATA_W     = 8,
    parameter int                 K          = 3,
    parameter int                 N_OUT      = 3,
    parameter int                 LAST_N     = 1,
    parameter int                 ROWS       = 10,
    parameter logic [ADDR_W-1:0]  PE_ADDR    = 4'b1011,
    parameter logic [ADDR_W-1:0]  DST_BASE   = 4'b0011,
    parameter logic [ADDR_W-1:0]  DST_STRIDE = 4'b0100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err_type
);

    localparam int HDR_W  = hdr_w(ADDR_W);
    localparam int PAY_W  = WIDTH - HDR_W;
    localparam int PSUM_W = DATA_W + $clog2(K);
    localparam int W_W    = K * DATA_W;
    localparam int M_W    = K + N_OUT - 1;
    localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    if ((PAY_W < W_W) || (PAY_W < M_W) || (PAY_W < PSUM_W) ||
        (LAST_N < 1) || (LAST_N > N_OUT)) begin : g_bad_params
        $fatal(1, "pe_conv_row: illegal parameter set");
    end

    state_e             state_q;
    logic               filt_vld_q, map_vld_q;
    logic [W_W-1:0]     w_q, w_d;
    logic [M_W-1:0]     m_q, m_d;
    logic [IDX_W-1:0]   idx_q, psum_idx_s, last_idx_s;
    logic [ROW_W-1:0]   row_cnt_q;
    logic               in_ready_q, out_valid_q, err_q;
    logic [WIDTH-1:0]   out_data_q, pkt_s;
    logic [TYPE_W-1:0]  pkt_type_s;
    logic [ADDR_W-1:0]  dst_s;
    logic [PSUM_W-1:0]  psum_s;
    logic               in_hs_s, is_filt_s, is_map_s, is_bad_s;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_type  = err_q;

    assign pkt_type_s = in_data[WIDTH-1-type_msb_ofs(ADDR_W) -: TYPE_W];
    assign in_hs_s    = in_valid && in_ready_q;
    assign is_filt_s  = in_hs_s && (pkt_type_s == PKT_FILTER);
    assign is_map_s   = in_hs_s && (pkt_type_s == PKT_IFMAP);
    assign is_bad_s   = in_hs_s && !is_filt_s && !is_map_s;
    assign last_idx_s = (row_cnt_q == ROW_W'(ROWS - 1)) ? IDX_W'(LAST_N - 1) : IDX_W'(N_OUT - 1);

    // Operands for the packet registered on the next edge: the incoming payload
    // when a row completes, otherwise the stored row with the following index.
    always_comb begin
        w_d        = is_filt_s ? in_data[W_W-1:0] : w_q;
        m_d        = is_map_s  ? in_data[M_W-1:0] : m_q;
        psum_idx_s = (state_q == SEND) ? (idx_q + IDX_W'(1)) : IDX_W'(0);
        dst_s      = DST_BASE + ADDR_W'(psum_idx_s) * DST_STRIDE;
        pkt_s                                         = '0;
        pkt_s[WIDTH-1 -: ADDR_W]                      = PE_ADDR;
        pkt_s[WIDTH-1-dst_msb_ofs(ADDR_W) -: ADDR_W]  = dst_s;
        pkt_s[WIDTH-1-type_msb_ofs(ADDR_W) -: TYPE_W] = PKT_PSUM;
        pkt_s[PSUM_W-1:0]                             = psum_s;
    end

    pe_psum_unit #(
        .DATA_W (DATA_W),
        .K      (K),
        .N_OUT  (N_OUT),
        .IDX_W  (IDX_W),
        .PSUM_W (PSUM_W)
    ) u_psum (
        .w_i    (w_d),
        .m_i    (m_d),
        .idx_i  (psum_idx_s),
        .psum_o (psum_s)
    );

    // Collect/send controller with registered handshake and packet outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            filt_vld_q  <= 1'b0;
            map_vld_q   <= 1'b0;
            w_q         <= '0;
            m_q         <= '0;
            idx_q       <= '0;
            row_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    err_q       <= is_bad_s;
                    w_q         <= w_d;
                    m_q         <= m_d;
                    if (is_filt_s) filt_vld_q <= 1'b1;
                    if (is_map_s)  map_vld_q  <= 1'b1;
                    if ((filt_vld_q || is_filt_s) && (map_vld_q || is_map_s)) begin
                        state_q     <= SEND;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= pkt_s;
                        in_ready_q  <= 1'b0;
                    end
                end
                SEND: begin
                    err_q      <= 1'b0;
                    in_ready_q <= 1'b0;
                    if (out_valid_q && out_ready) begin
                        if (idx_q == last_idx_s) begin
                            filt_vld_q  <= 1'b0;
                            map_vld_q   <= 1'b0;
                            row_cnt_q   <= (row_cnt_q == ROW_W'(ROWS - 1)) ? ROW_W'(0)
                                                                           : row_cnt_q + ROW_W'(1);
                            state_q     <= COLLECT;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            idx_q      <= idx_q + IDX_W'(1);
                            out_data_q <= pkt_s;
                        end
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    err_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pe_conv_row.md
# pe_conv_row

Clocked, parametrised successor of the SNN convolution PE. It collects one filter-row packet (K weights) and one ifmap packet (K+N_OUT−1 spike bits) from the NoC, then computes N_OUT partial sums. Each sum goes out as its own packet to a configurable sum-and-threshold node. A row counter shortens the output burst on the last row of each ROWS-long cycle. It sits between the router port and the NoC, and uses valid/ready handshakes on both sides.

## Interface
- WIDTH, 35: packet width.
- ADDR_W, 4: node address width.
- DATA_W, 8: weight width.
- K, 3: filter taps.
- N_OUT, 3: psums per full row.
- LAST_N, 1: psums sent on the last row (1..N_OUT).
- ROWS, 10: rows per cycle. Row counter period.
- PE_ADDR, 4'b1011: this node's address.
- DST_BASE, 4'b0011: destination address of psum 0.
- DST_STRIDE, 4'b0100: destination of psum i is DST_BASE + i·DST_STRIDE, mod 2^ADDR_W.
- PSUM_W, derived: DATA_W + $clog2(K).
- Legal parameter set: WIDTH−11 ≥ max(K·DATA_W, K+N_OUT−1, PSUM_W). Elaboration fatal otherwise.
- clk  in  1  sole clock. Rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input packet valid.
- in_ready  out  1  PE can accept an input packet.
- in_data  in  WIDTH  packet: [W−1:W−4] src, [W−5:W−8] dst, [W−9:W−11] type, low bits payload.
- out_valid  out  1  psum packet valid.
- out_ready  in  1  NoC accepts the psum packet.
- out_data  out  WIDTH  {PE_ADDR, dst_i, 3'b010, zero pad, psum zero-extended}.
- err_type  out  1  one-cycle pulse when an input packet has an unknown type.

## Operation
- Packet types:
  - 3'b000 FILTER: weights w[k] = payload[8k+7:8k], k=0..K−1. w[K−1] is the most significant.
  - 3'b001 IFMAP: spike bits m[j] = payload[j], j=0..K+N_OUT−2.
  - Any other type: packet is consumed and dropped, and err_type pulses.
- psum i = Σ_{k=0..K−1} (m[K+N_OUT−2−i−k] ? w[K−1−k] : 0). Unsigned, PSUM_W bits, cannot overflow.
- Two states:
  - COLLECT:
    - in_ready=1.
    - On each handshake, store the payload and set filt_vld or map_vld.
    - A repeated packet of the same type overwrites the stored value and keeps its flag set.
    - When both flags are set after a handshake, go to SEND with idx=0.
  - SEND:
    - in_ready=0.
    - out_valid=1 with the packet for idx.
    - On out_valid&&out_ready: if idx == n_send−1, clear both flags, advance row_cnt, and return to COLLECT. Otherwise increment idx and load the next packet.
- n_send = LAST_N when row_cnt == ROWS−1, else N_OUT.
- row_cnt wraps from ROWS−1 to 0.
- Stored weights persist across rows. Both flags must still be re-set for every row.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, err_type=0, row_cnt=0, idx=0, both flags 0, state COLLECT.
- in_ready=1 in the first cycle after rst deasserts.
- in_ready, out_valid and out_data are registered.
- Latency: the packet for psum 0 is valid in the cycle after the completing input handshake.
- Each later psum is valid in the cycle after the previous output handshake. With out_ready held high, one packet per cycle.
- in_ready drops in the same cycle out_valid rises, and rises in the cycle after the final output handshake.
- out_data is stable while out_valid && !out_ready.
- in_valid during SEND is ignored and back-pressured.
- rst asserted mid-burst: the next edge aborts the burst. out_valid=0 immediately, remaining psums are lost, and stored data and counters are cleared.

## Structure
- Package pe_pkg holds:
  - type constants PKT_FILTER=3'b000, PKT_IFMAP=3'b001, PKT_PSUM=3'b010
  - state enum {COLLECT, SEND}
  - header field offset constants
- Sub-module pe_psum_unit: combinational K-tap spike-gated adder, inputs (w, m, idx), output psum. Shared by all N_OUT outputs through idx.

## Test plan
- Filter payload 0x050302, then IFMAP 5'b10110, out_ready=1 → three packets to dst 3, 7, 11 with psums 7, 5, 8 in three consecutive cycles starting one cycle after the IFMAP handshake.
- IFMAP first, then FILTER → same three psums. Order is irrelevant.
- out_ready low for 4 cycles on psum 1 → out_data held at psum 5 and in_ready stays 0; the burst resumes after out_ready rises.
- Ten rows of the same packets → rows 0–8 send 3 packets each, row 9 sends only psum 7 to dst 3, and row 10 sends 3 packets again (counter wrapped).
- Type 3'b111 input → consumed, err_type pulses one cycle, no output, flags unchanged.
- rst asserted after the first psum of a burst → out_valid 0 the next cycle, in_ready 0 while reset is held, and a new row then needs both packets again.
